// File: rtl/spi_slave_ctrl.sv
// SPI slave bit engine: oversamples SCK/SS_n/MOSI on clk, decodes CPOL/CPHA edges,
// deserialises MOSI into rx words and serialises a buffered tx word onto MISO, MSB first.
module spi_slave_ctrl #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  CPOL,
    input  logic                  CPHA,
    input  logic                  SCK_in,
    input  logic                  SS_n,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic                  MISO_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ack,
    output logic                  busy,
    output logic                  overrun,
    output logic                  underrun
);

    localparam int unsigned CntW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

    typedef enum logic {StIdle, StActive} state_e;

    state_e                state_q, state_d;
    logic                  sck_s1_q, sck_s2_q, sck_prev_q;
    logic                  ss_s1_q, ss_s2_q;
    logic                  mosi_s1_q, mosi_s2_q;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
    logic                  tx_ready_q, tx_ready_d;
    logic                  miso_q, miso_d;
    logic                  overrun_q, overrun_d;
    logic                  underrun_q, underrun_d;

    logic                  active;
    logic                  sck_edge, lead_edge, trail_edge;
    logic                  sample_ev, shift_ev;
    logic                  reload, word_done;
    logic [DATA_WIDTH-1:0] rx_word;

    // Edges only count while selected; leading edge leaves the CPOL idle level.
    assign active     = (state_q == StActive);
    assign sck_edge   = active && (sck_s2_q != sck_prev_q);
    assign lead_edge  = sck_edge && (sck_s2_q != CPOL);
    assign trail_edge = sck_edge && (sck_s2_q == CPOL);
    assign sample_ev  = CPHA ? trail_edge : lead_edge;
    assign shift_ev   = CPHA ? lead_edge : trail_edge;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        tx_shift_d = tx_shift_q;
        tx_buf_d   = tx_buf_q;
        tx_ready_d = tx_ready_q;
        overrun_d  = overrun_q;
        underrun_d = underrun_q;
        miso_d     = tx_shift_q[DATA_WIDTH-1];
        reload     = 1'b0;
        word_done  = 1'b0;
        rx_word    = {rx_shift_q[DATA_WIDTH-2:0], mosi_s2_q};

        unique case (state_q)
            StIdle: begin
                if (!ss_s2_q) begin
                    state_d = StActive;
                    cnt_d   = '0;
                    reload  = !CPHA;
                end
            end
            StActive: begin
                if (ss_s2_q) begin
                    // Deselect mid-word drops the partial word.
                    state_d    = StIdle;
                    cnt_d      = '0;
                    rx_shift_d = '0;
                end else begin
                    if (sample_ev) begin
                        rx_shift_d = rx_word;
                        if (cnt_q == LastBit) begin
                            cnt_d      = '0;
                            rx_data_d  = rx_word;
                            rx_valid_d = 1'b1;
                            word_done  = 1'b1;
                            if (rx_valid_q && !rx_ack) overrun_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                    // Counter at 0 on a shift edge means a new word starts here.
                    if (shift_ev) begin
                        if (cnt_q == '0) reload = 1'b1;
                        else tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (rx_ack && rx_valid_q && !word_done) rx_valid_d = 1'b0;

        if (reload) begin
            tx_shift_d = tx_ready_q ? '1 : tx_buf_q;
            if (tx_ready_q) underrun_d = 1'b1;
            tx_ready_d = 1'b1;
        end
        // Acceptance uses the registered flag so a same-cycle reload sees the old buffer.
        if (tx_load && tx_ready_q) begin
            tx_buf_d   = tx_data;
            tx_ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            sck_s1_q   <= 1'b0;
            sck_s2_q   <= 1'b0;
            sck_prev_q <= 1'b0;
            ss_s1_q    <= 1'b1;
            ss_s2_q    <= 1'b1;
            mosi_s1_q  <= 1'b0;
            mosi_s2_q  <= 1'b0;
            cnt_q      <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_shift_q <= '0;
            tx_buf_q   <= '0;
            tx_ready_q <= 1'b1;
            miso_q     <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sck_s1_q   <= SCK_in;
            sck_s2_q   <= sck_s1_q;
            sck_prev_q <= sck_s2_q;
            ss_s1_q    <= SS_n;
            ss_s2_q    <= ss_s1_q;
            mosi_s1_q  <= MOSI;
            mosi_s2_q  <= mosi_s1_q;
            cnt_q      <= cnt_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_shift_q <= tx_shift_d;
            tx_buf_q   <= tx_buf_d;
            tx_ready_q <= tx_ready_d;
            miso_q     <= miso_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
        end
    end

    assign MISO     = miso_q;
    assign MISO_oe  = active;
    assign busy     = active;
    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign overrun  = overrun_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: a bit-banged SPI master drives the pins and a
// scoreboard queue holds the words the slave should receive and the master should see.
module tb_spi_slave_ctrl;

    localparam int W = 8;
    localparam int H = 6;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         CPOL = 1'b0, CPHA = 1'b0;
    logic         SCK_in = 1'b0, SS_n = 1'b1, MOSI = 1'b0;
    logic         MISO, MISO_oe;
    logic [W-1:0] tx_data = '0;
    logic         tx_load = 1'b0;
    logic         tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         rx_ack = 1'b0;
    logic         busy, overrun, underrun;

    int n_chk = 0;
    int n_err = 0;
    logic [15:0] exp_rx[$];
    logic [15:0] exp_miso[$];

    spi_slave_ctrl #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .CPOL(CPOL), .CPHA(CPHA), .SCK_in(SCK_in), .SS_n(SS_n),
        .MOSI(MOSI), .MISO(MISO), .MISO_oe(MISO_oe), .tx_data(tx_data), .tx_load(tx_load),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
        .busy(busy), .overrun(overrun), .underrun(underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input logic cpol, input logic cpha);
        rst = 1'b1; SS_n = 1'b1; SCK_in = cpol; CPOL = cpol; CPHA = cpha;
        MOSI = 1'b0; tx_load = 1'b0; rx_ack = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(4);
    endtask

    task automatic load(input logic [W-1:0] v);
        tx_data = v; tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
    endtask

    task automatic ack();
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
    endtask

    // Master: MSB first; samples MISO just before its sampling edge.
    task automatic xfer(input logic cpol, input logic cpha, input logic [15:0] word,
                        input int nbits, output logic [15:0] got);
        got = '0;
        SCK_in = cpol; SS_n = 1'b0;
        if (!cpha) MOSI = word[nbits-1];
        tick(8);
        chk("busy_sel", busy, 1);
        chk("oe_sel", MISO_oe, 1);
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) got = {got[14:0], MISO};
            else MOSI = word[nbits-1-i];
            SCK_in = ~cpol;
            tick(H);
            if (cpha) got = {got[14:0], MISO};
            SCK_in = cpol;
            if (!cpha && i < nbits - 1) MOSI = word[nbits-2-i];
            tick(H);
        end
        tick(4);
        SS_n = 1'b1;
        tick(6);
    endtask

    task automatic check_miso(input string tag, input logic [15:0] got);
        logic [15:0] e;
        if (exp_miso.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = exp_miso.pop_front();
            chk(tag, got, e);
        end
    endtask

    task automatic check_rx(input string tag, input logic [15:0] got);
        logic [15:0] e;
        if (exp_rx.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = exp_rx.pop_front();
            chk(tag, got, e);
        end
    endtask

    initial begin
        logic [15:0] got;
        logic [15:0] first_rx;
        logic        ready_seen, valid_seen;

        // Reset values
        do_reset(1'b0, 1'b0);
        chk("rst_miso", MISO, 0);
        chk("rst_oe", MISO_oe, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_underrun", underrun, 0);

        // Single word in every mode, with SCK wiggled while deselected first
        for (int m = 0; m < 4; m++) begin
            do_reset(m[1], m[0]);
            for (int k = 0; k < 3; k++) begin
                SCK_in = ~m[1]; tick(H);
                SCK_in = m[1];  tick(H);
            end
            chk("idle_busy", busy, 0);
            chk("idle_rx_valid", rx_valid, 0);
            load(8'hA5);
            chk("load_tx_ready", tx_ready, 0);
            exp_rx.push_back(16'h003C);
            exp_miso.push_back(16'h00A5);
            xfer(m[1], m[0], 16'h003C, 8, got);
            check_miso("mode_miso", got);
            check_rx("mode_rx_data", {8'h00, rx_data});
            chk("mode_rx_valid", rx_valid, 1);
            chk("mode_tx_ready", tx_ready, 1);
            chk("mode_oe_off", MISO_oe, 0);
        end

        // Two words under one select, mode 3, second buffer loaded once the first is taken
        do_reset(1'b1, 1'b1);
        load(8'h81);
        exp_miso.push_back(16'h817E);
        exp_rx.push_back(16'h0012);
        exp_rx.push_back(16'h0034);
        ready_seen = 1'b0;
        valid_seen = 1'b0;
        first_rx   = '0;
        fork
            xfer(1'b1, 1'b1, 16'h1234, 16, got);
            begin
                for (int k = 0; k < 300 && !ready_seen; k++) begin
                    tick(1);
                    if (tx_ready) ready_seen = 1'b1;
                end
                if (ready_seen) load(8'h7E);
            end
            begin
                for (int k = 0; k < 400 && !valid_seen; k++) begin
                    tick(1);
                    if (rx_valid) begin
                        valid_seen = 1'b1;
                        first_rx   = {8'h00, rx_data};
                    end
                end
            end
        join
        chk("b2b_ready_seen", ready_seen, 1);
        chk("b2b_valid_seen", valid_seen, 1);
        check_rx("b2b_rx_first", first_rx);
        check_miso("b2b_miso", got);
        check_rx("b2b_rx_second", {8'h00, rx_data});
        chk("b2b_rx_valid", rx_valid, 1);
        chk("b2b_overrun", overrun, 1);
        chk("b2b_underrun", underrun, 0);
        ack();
        chk("ack_rx_valid", rx_valid, 0);
        chk("ack_overrun_sticky", overrun, 1);

        // Empty tx buffer at select
        do_reset(1'b0, 1'b0);
        exp_miso.push_back(16'h00FF);
        exp_rx.push_back(16'h0066);
        xfer(1'b0, 1'b0, 16'h0066, 8, got);
        check_miso("empty_miso", got);
        check_rx("empty_rx_data", {8'h00, rx_data});
        chk("empty_underrun", underrun, 1);

        // Deselect after 5 bits, then a clean full word
        do_reset(1'b0, 1'b0);
        load(8'hA5);
        xfer(1'b0, 1'b0, 16'h001F, 5, got);
        chk("part_rx_valid", rx_valid, 0);
        chk("part_oe", MISO_oe, 0);
        chk("part_busy", busy, 0);
        load(8'hC3);
        exp_rx.push_back(16'h005A);
        exp_miso.push_back(16'h00C3);
        xfer(1'b0, 1'b0, 16'h005A, 8, got);
        check_rx("after_part_rx", {8'h00, rx_data});
        check_miso("after_part_miso", got);
        chk("after_part_valid", rx_valid, 1);

        // Reset in the middle of a word with pins left active
        load(8'hF0);
        SS_n = 1'b0; MOSI = 1'b1;
        tick(8);
        SCK_in = 1'b1; tick(H);
        SCK_in = 1'b0; tick(H);
        SCK_in = 1'b1; tick(H);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_miso", MISO, 0);
        chk("mid_rst_oe", MISO_oe, 0);
        chk("mid_rst_rx_data", rx_data, 0);
        chk("mid_rst_rx_valid", rx_valid, 0);
        chk("mid_rst_tx_ready", tx_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_overrun", overrun, 0);
        chk("mid_rst_underrun", underrun, 0);
        rst = 1'b0; SS_n = 1'b1; SCK_in = 1'b0;
        tick(4);

        chk("sb_drained", exp_rx.size() + exp_miso.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_slave_ctrl.md
# spi_slave_ctrl

SPI slave-side bit engine: the receiving end of the master-generated SCK. It takes SCK, SS_n and MOSI from the bus, oversamples them on the local system clock and derives sample and shift events for the selected CPOL/CPHA mode. It deserialises MOSI into words and serialises a buffered transmit word onto MISO, MSB first. It sits between the SPI pins and the slave's register/FIFO logic.

## Interface
- DATA_WIDTH, 8, word length in bits (≥2)
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- CPOL  in  1  SCK idle level; must be static while SS_n low
- CPHA  in  1  0: sample on leading edge; 1: sample on trailing edge; static while SS_n low
- SCK_in  in  1  bus clock from master, asynchronous
- SS_n  in  1  slave select, active-low, asynchronous
- MOSI  in  1  master-out data, asynchronous
- MISO  out  1  slave-out data
- MISO_oe  out  1  MISO output enable (tri-state control at pad)
- tx_data  in  DATA_WIDTH  word to transmit
- tx_load  in  1  write tx_data into tx buffer
- tx_ready  out  1  tx buffer empty, tx_load accepted
- rx_data  out  DATA_WIDTH  last received word
- rx_valid  out  1  rx_data holds an unacknowledged word
- rx_ack  in  1  consume rx_data
- busy  out  1  selected (synchronised SS_n low)
- overrun  out  1  sticky: word completed while rx_valid high
- underrun  out  1  sticky: reload found tx buffer empty

## Operation
- Synchronisers: 2-flop on SCK_in, SS_n, MOSI; edge detect compares synchronised SCK to its previous sample.
- Leading edge: synced SCK leaves CPOL; trailing edge: returns to CPOL. Edges ignored while synced SS_n high.
- States: IDLE (SS_n high), ACTIVE. IDLE→ACTIVE on synced SS_n fall; ACTIVE→IDLE on synced SS_n rise from any bit position.
- Sample event: leading (CPHA=0) or trailing (CPHA=1). Shifts synced MOSI into rx shift register LSB, increments bit counter 0..DATA_WIDTH-1, wraps to 0 at DATA_WIDTH.
- Word complete (DATA_WIDTH-th sample): rx_data ← assembled word next cycle, rx_valid←1; if rx_valid already 1 and no rx_ack that cycle, overrun←1, rx_data overwritten.
- rx_ack with rx_valid high clears rx_valid; same-cycle completion wins (rx_valid stays 1, no overrun).
- MISO = tx shift register MSB. Reload = tx shift reg ← tx buffer, tx_ready←1; if buffer empty load all-ones, underrun←1.
- CPHA=0: reload at SS_n fall and on trailing edge following the last sample of a word; other trailing edges shift left.
- CPHA=1: reload on leading edge with bit counter 0; other leading edges shift left.
- tx_load with tx_ready high: buffer ← tx_data, tx_ready←0. tx_load with tx_ready low ignored. Load and reload same cycle: reload takes old buffer (or all-ones if empty), new data captured.
- SS_n rise mid-word: partial rx discarded, counter←0, no rx_valid, MISO_oe←0; consumed tx word lost.
- MISO_oe = busy.

## Timing
- Reset values: MISO 0, MISO_oe 0, rx_data 0, rx_valid 0, tx_ready 1, busy 0, overrun 0, underrun 0; counter 0, state IDLE.
- Pin-to-event latency: 3 clk (2 sync + 1 edge detect). MISO updates 4 clk after the SCK pin edge.
- Requirement: SCK high and low phases ≥ 4 clk; SS_n fall to first SCK edge ≥ 4 clk.
- rx_valid rises 1 clk after the completing sample event.
- Back-to-back words under continuous SS_n supported with no gap.
- Reset mid-transfer returns to reset values next clk regardless of pins.

## Test plan
- Mode 0, tx buffer 0xA5, master sends 0x3C, SCK half-period 6 clk -> rx_data 0x3C, rx_valid 1; master samples MISO 0xA5; tx_ready 1 after SS_n fall.
- Modes 1, 2, 3 same stimulus -> same 0x3C / 0xA5 each; no edge decoded while SS_n high.
- Two words under one SS_n, mode 3, buffer 0x81 then 0x7E loaded after first tx_ready -> MISO 0x81,0x7E; MOSI 0x12,0x34 received; no underrun.
- Second word with no rx_ack -> rx_data 0x34, rx_valid 1, overrun 1; then rx_ack -> rx_valid 0, overrun stays 1.
- Empty tx buffer at SS_n fall, mode 0 -> MISO 0xFF, underrun 1.
- SS_n released after 5 bits -> no rx_valid, MISO_oe 0; next full transfer 0x5A received correctly; rst mid-word -> all outputs reset values.
